// File: rtl/voice_scheduler_pkg.sv
// Shared definitions for the voice scheduler: FSM state type, voice count
// and the accumulator width rule.
package voice_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int NV = 4;

  // Two guard bits let four full-scale voices sum without wrapping.
  function automatic int acc_width(input int m);
    return m + 2;
  endfunction

endpackage

// File: rtl/voice_scheduler.sv
// Time-multiplexed mixer: walks an external 4:1 voice mux over four cycles,
// sums the enabled voices and publishes their truncated average.
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int M = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [3:0]   en_mask,
  input  logic [1:0]   mon_sel,
  input  logic         clr_ovr,
  input  logic [M-1:0] mux_in,
  output logic [1:0]   sel,
  output logic [M-1:0] mix_out,
  output logic         mix_valid,
  output logic         busy,
  output logic         overrun
);

  localparam int AW = acc_width(M);

  state_t         state, state_n;
  logic [1:0]     cnt;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  sum;
  logic [NV-1:0]  mask_q;
  logic           last;

  assign last = (cnt == 2'(NV - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (tick) state_n = SCAN;
      SCAN:    if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sum = acc + (mask_q[cnt] ? AW'(mux_in) : '0);
  end

  assign sel  = (state == SCAN) ? cnt : mon_sel;
  assign busy = (state == SCAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      mask_q    <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      // A tick while scanning sets the flag even if a clear arrives together.
      if (state == SCAN && tick) overrun <= 1'b1;
      else if (clr_ovr)          overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            cnt    <= '0;
            acc    <= '0;
            mask_q <= en_mask;
          end
        end
        SCAN: begin
          acc <= sum;
          cnt <= cnt + 2'd1;
          if (last) begin
            mix_out   <= sum[AW-1:2];
            mix_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Scoreboard bench for voice_scheduler: stimulus pushes expected mixes,
// a negedge monitor pops them when mix_valid appears.
module tb_voice_scheduler;

  localparam int M = 12;

  typedef struct {
    logic [M-1:0] value;
    int           cycle;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tick = 1'b0;
  logic [3:0]   en_mask = 4'h0;
  logic [1:0]   mon_sel = 2'd0;
  logic         clr_ovr = 1'b0;
  logic [M-1:0] mux_in;
  logic [1:0]   sel;
  logic [M-1:0] mix_out;
  logic         mix_valid;
  logic         busy;
  logic         overrun;

  logic [M-1:0] voices [4];
  exp_t         sb [$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  assign mux_in = voices[sel];

  voice_scheduler #(.M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .en_mask   (en_mask),
    .mon_sel   (mon_sel),
    .clr_ovr   (clr_ovr),
    .mux_in    (mux_in),
    .sel       (sel),
    .mix_out   (mix_out),
    .mix_valid (mix_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mix_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got mix_valid=1 mix_out=0x%0h expected no pulse (cycle %0d)",
                 mix_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mix_out", 32'(mix_out), 32'(e.value));
        chk("latency", 32'(cyc), 32'(e.cycle));
      end
    end
  end

  task automatic issue_tick(input logic [3:0] mask, input logic [M-1:0] exp);
    exp_t e;
    tick    = 1'b1;
    en_mask = mask;
    e.value = exp;
    e.cycle = cyc + 5;
    sb.push_back(e);
  endtask

  // Called on a negedge; returns on the negedge in the mix_valid cycle.
  task automatic run_mix(input logic [3:0] mask, input logic [M-1:0] exp);
    issue_tick(mask, exp);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tick = 1'b0;
      chk("busy_scan", 32'(busy), 32'd1);
      chk("sel_step", 32'(sel), 32'(i));
    end
    @(negedge clk);
    chk("busy_done", 32'(busy), 32'd0);
  endtask

  task automatic check_hold(input logic [M-1:0] exp);
    @(negedge clk);
    chk("hold_value", 32'(mix_out), 32'(exp));
    chk("hold_novalid", 32'(mix_valid), 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    voices[0] = 12'h100; voices[1] = 12'h200;
    voices[2] = 12'h300; voices[3] = 12'h400;
    mon_sel = 2'd2;

    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mix_out", 32'(mix_out), 32'd0);
    chk("rst_valid", 32'(mix_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_sel", 32'(sel), 32'd2);
    rst = 1'b0;
    @(negedge clk);
    mon_sel = 2'd1;
    #1 chk("idle_sel", 32'(sel), 32'd1);

    @(negedge clk);
    run_mix(4'b1111, 12'h280);
    check_hold(12'h280);
    run_mix(4'b0101, 12'h100);
    check_hold(12'h100);
    run_mix(4'b0000, 12'h000);
    check_hold(12'h000);

    voices[0] = 12'hFFF; voices[1] = 12'hFFF;
    voices[2] = 12'hFFF; voices[3] = 12'hFFF;
    @(negedge clk);
    run_mix(4'b1111, 12'hFFF);
    check_hold(12'hFFF);

    // Overrun: extra tick two cycles into the scan.
    voices[0] = 12'h100; voices[1] = 12'h200;
    voices[2] = 12'h300; voices[3] = 12'h400;
    @(negedge clk);
    issue_tick(4'b1111, 12'h280);
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("overrun_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    chk("mv_cycle_valid", 32'(mix_valid), 32'd1);
    chk("overrun_held", 32'(overrun), 32'd1);
    issue_tick(4'b0011, 12'h0C0);
    @(negedge clk);
    tick = 1'b0;
    chk("back_to_back_busy", 32'(busy), 32'd1);
    chk("back_to_back_sel", 32'(sel), 32'd0);
    @(negedge clk);
    // Set and clear on the same edge: set must win.
    tick = 1'b1;
    clr_ovr = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    clr_ovr = 1'b0;
    chk("set_wins", 32'(overrun), 32'd1);
    repeat (3) @(negedge clk);
    check_hold(12'h0C0);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("overrun_clr", 32'(overrun), 32'd0);

    // Abort by reset in the second scan cycle.
    mon_sel = 2'd3;
    tick = 1'b1;
    en_mask = 4'b1111;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mix_out", 32'(mix_out), 32'd0);
    chk("abort_sel", 32'(sel), 32'd3);
    repeat (5) @(negedge clk);
    chk("abort_no_result", 32'(mix_out), 32'd0);

    // Mask changed mid-scan must not affect the result.
    issue_tick(4'b1111, 12'h280);
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    en_mask = 4'b0000;
    repeat (3) @(negedge clk);
    en_mask = 4'b1000;
    check_hold(12'h280);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 SHALL have parameter: M, default 12, voice sample and mixed output width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: tick  input  1  sample strobe; requests one mix of all voices.
REQ-005 SHALL have port: en_mask  input  4  per-voice enable; bit i enables voice i.
REQ-006 SHALL have port: mon_sel  input  2  voice index driven on sel while idle (monitor/test path).
REQ-007 SHALL have port: clr_ovr  input  1  clears the overrun flag.
REQ-008 SHALL have port: mux_in  input  M  sample returned by the external 4:1 voice mux (combinational from sel).
REQ-009 SHALL have port: sel  output  2  voice select driven to the external 4:1 voice mux.
REQ-010 SHALL have port: mix_out  output  M  registered averaged mix of the enabled voices.
REQ-011 SHALL have port: mix_valid  output  1  one-cycle pulse marking a new mix_out.
REQ-012 SHALL have port: busy  output  1  high while a scan is in progress.
REQ-013 SHALL have port: overrun  output  1  sticky flag; a tick arrived while busy.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and SCAN.
REQ-015 In IDLE, tick=1 at an edge SHALL: enter SCAN; clear voice counter cnt and accumulator acc to 0; latch en_mask into mask_q.
REQ-016 In SCAN, sel SHALL equal cnt; in IDLE, sel SHALL equal mon_sel.
REQ-017 At each SCAN edge: acc SHALL gain mux_in (zero-extended) when mask_q[cnt]=1, else 0; cnt SHALL increment.
REQ-018 acc SHALL be M+2 bits, unsigned; four maximal voices SHALL never overflow it.
REQ-019 At the SCAN edge with cnt=3, mix_out SHALL load bits [M+1:2] of the final sum (the sum divided by 4, truncated), mix_valid SHALL be 1 for the following cycle, and the FSM SHALL return to IDLE.
REQ-020 Latency SHALL be fixed: tick sampled at edge E0; voices 0..3 accumulated at E1..E4; mix_valid high in the cycle after E4.
REQ-021 Throughput SHALL be one mix per 5 cycles; a tick during the mix_valid cycle SHALL be accepted.
REQ-022 busy SHALL equal (state==SCAN).
REQ-023 A tick sampled in SCAN SHALL be ignored and SHALL set overrun; the scan in progress SHALL be unaffected.
REQ-024 clr_ovr=1 SHALL clear overrun; if tick-in-SCAN and clr_ovr occur on the same edge, set SHALL win.
REQ-025 en_mask changes during SCAN SHALL have no effect until the next accepted tick.
REQ-026 mix_out SHALL hold its value between mix_valid pulses.
REQ-027 en_mask=0000 SHALL produce mix_out=0 with a normal mix_valid pulse.

Reset
REQ-028 rst=1 at an edge SHALL force: state=IDLE, cnt=0, acc=0, mask_q=0, mix_out=0, mix_valid=0, overrun=0; rst SHALL take priority over all other inputs.
REQ-029 Reset asserted mid-scan SHALL abort the scan, and no mix_valid SHALL follow it.
REQ-030 After reset, sel SHALL equal mon_sel (IDLE behaviour) and busy SHALL be 0.

Structure
REQ-031 A shared package SHALL hold the FSM state type (IDLE, SCAN), the constant NV=4, and the accumulator-width rule M+2.
REQ-032 SHALL be a single module with no sub-module; the 4:1 voice mux remains external, driven by sel and returning mux_in.

Verification
REQ-033 Reset check: assert rst 2 cycles -> mix_out=0, mix_valid=0, busy=0, overrun=0, sel=mon_sel.
REQ-034 Full mix: M=12, voices 0x100/0x200/0x300/0x400, en_mask=1111, tick -> sel steps 0,1,2,3; mix_valid exactly 5 cycles after the tick edge; mix_out=0x280.
REQ-035 Masked mix: same voices, en_mask=0101 -> mix_out=0x100; en_mask=0000 -> mix_out=0x000 with mix_valid pulse.
REQ-036 Max values: all voices 0xFFF, en_mask=1111 -> mix_out=0xFFF (no wrap).
REQ-037 Overrun: tick again 2 cycles into a scan -> result unchanged (0x280), overrun=1, held until clr_ovr pulse -> 0; tick during mix_valid cycle -> next scan starts.
REQ-038 Abort: rst at 2nd SCAN cycle -> IDLE next cycle, no mix_valid, mix_out=0; en_mask toggled mid-scan -> result uses latched mask.
